// File: rtl/axi_alu_pkg.sv
// Shared types for the AXI ALU compute stage: ALU opcodes, sequencer states
// and the mask that flags opcodes outside the 3-bit operation space.
package axi_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    SEQ_OP   = 3'd0,
    SEQ_A    = 3'd1,
    SEQ_B    = 3'd2,
    SEQ_EXEC = 3'd3,
    SEQ_RESP = 3'd4
  } seq_state_e;

  localparam logic [7:0] OP_ILLEGAL_MASK = 8'hF8;

endpackage

// File: rtl/axi_alu_sequencer_if.sv
// Byte-stream input and result output channels of the sequencer.
// Both channels: a transfer happens on a rising edge where valid && ready;
// the valid side holds its data stable until that edge.
interface axi_alu_sequencer_if #(parameter int DW = 8);
  logic [DW-1:0]   s_rdata;
  logic            s_rvalid;
  logic            s_rready;
  logic [2*DW-1:0] res_data;
  logic            res_err;
  logic            res_valid;
  logic            res_ready;

  // Environment side: the FIFO feeding bytes and the consumer taking results.
  modport master (
    output s_rdata, s_rvalid, res_ready,
    input  s_rready, res_data, res_err, res_valid
  );

  // Sequencer side.
  modport slave (
    input  s_rdata, s_rvalid, res_ready,
    output s_rready, res_data, res_err, res_valid
  );
endinterface

// File: rtl/axi_alu_sequencer_alu_exec.sv
// Combinational ALU: one operation on zero-extended operands, 2*DW-bit result.
module alu_exec
  import axi_alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  alu_op_e         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] y
);

  logic [2*DW-1:0] ax;
  logic [2*DW-1:0] bx;

  assign ax = {{DW{1'b0}}, a};
  assign bx = {{DW{1'b0}}, b};

  // Shifts use only the low three bits of B so the amount stays within a byte.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = ax + bx;
      OP_SUB:  y = ax - bx;
      OP_AND:  y = ax & bx;
      OP_OR:   y = ax | bx;
      OP_XOR:  y = ax ^ bx;
      OP_MUL:  y = ax * bx;
      OP_SHL:  y = ax << b[2:0];
      OP_SHR:  y = ax >> b[2:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/axi_alu_sequencer.sv
// Frame sequencer: collects opcode/A/B bytes, runs one ALU operation per frame
// and holds the result on the result channel until it is taken.
module axi_alu_sequencer
  import axi_alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                reset,
  axi_alu_sequencer_if.slave  bus,
  output logic                busy,
  output logic [7:0]          op_count,
  output seq_state_e          dbg_state
);

  localparam logic [2:0] S_OP   = 3'd0;
  localparam logic [2:0] S_A    = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   op_q, a_q, b_q;
  logic [2*DW-1:0] res_data_q;
  logic            res_err_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [2*DW-1:0] alu_y;
  logic            accept;
  logic            take;
  logic            op_illegal;

  assign bus.s_rready  = (state_q == S_OP) || (state_q == S_A) || (state_q == S_B);
  assign bus.res_valid = (state_q == S_RESP);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign busy          = (state_q != S_OP);
  assign op_count      = cnt_q;
  assign dbg_state     = seq_state_e'(state_q);

  assign accept     = bus.s_rvalid && bus.s_rready;
  assign take       = bus.res_valid && bus.res_ready;
  assign op_illegal = |(op_q & OP_ILLEGAL_MASK[DW-1:0]);

  alu_exec #(.DW(DW)) u_alu (
    .op (alu_op_e'(op_q[2:0])),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OP:    if (accept) state_d = S_A;
      S_A:     if (accept) state_d = S_B;
      S_B:     if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (take) begin
                 state_d = S_OP;
                 cnt_d   = cnt_q + 8'd1;
               end
      default: state_d = S_OP;
    endcase
  end

  // Illegal frames still walk through A and B so the byte framing stays aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OP;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && state_q == S_OP) op_q <= bus.s_rdata;
      if (accept && state_q == S_A)  a_q  <= bus.s_rdata;
      if (accept && state_q == S_B)  b_q  <= bus.s_rdata;
      if (state_q == S_EXEC) begin
        res_data_q <= op_illegal ? '0 : alu_y;
        res_err_q  <= op_illegal;
      end
    end
  end

endmodule

// File: tb/tb_axi_alu_sequencer.sv
// Directed and randomized bench for axi_alu_sequencer, scored against a
// plain-arithmetic model of the frame rules.
module tb_axi_alu_sequencer;
  import axi_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] op_count;
  seq_state_e dbg_state;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cnt_model  = 0;
  int accept_cycles;

  logic [16:0] exp_q[$];

  axi_alu_sequencer_if #(.DW(8)) bus ();

  axi_alu_sequencer #(.DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .op_count  (op_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {err, data}.
  function automatic logic [16:0] model(input int op, input int a, input int b);
    int r;
    if (op > 7) return {1'b1, 16'h0000};
    case (op)
      0: r = a + b;
      1: r = a - b + 65536;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * b;
      6: r = a * (2 ** (b % 8));
      default: r = a / (2 ** (b % 8));
    endcase
    return {1'b0, 16'(r % 65536)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, input int gap);
    bit ok;
    int n;
    if (gap > 0) begin
      bus.s_rvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = b;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.s_rready;
      @(posedge clk); #1;
      n++;
      accept_cycles++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int op, input int a, input int b, input int maxgap);
    push_byte(8'(op), $urandom_range(0, maxgap));
    push_byte(8'(a),  $urandom_range(0, maxgap));
    push_byte(8'(b),  $urandom_range(0, maxgap));
    bus.s_rvalid = 1'b0;
    exp_q.push_back(model(op, a, b));
  endtask

  task automatic get_result(input int hold);
    int n;
    logic [16:0] exp;
    n = 0;
    while (!bus.res_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.res_valid) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_result", 32'd1, 32'd0);
      return;
    end
    exp = exp_q.pop_front();
    check("res_data", 32'(bus.res_data), 32'(exp[15:0]));
    check("res_err",  32'(bus.res_err),  32'(exp[16]));
    check("busy_resp", 32'(busy), 32'd1);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid",  32'(bus.res_valid), 32'd1);
      check("hold_data",   32'(bus.res_data),  32'(exp[15:0]));
      check("hold_err",    32'(bus.res_err),   32'(exp[16]));
      check("hold_rready", 32'(bus.s_rready),  32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    cnt_model = (cnt_model + 1) % 256;
    check("op_count", 32'(op_count), 32'(cnt_model));
    check("valid_after_take", 32'(bus.res_valid), 32'd0);
    check("rready_after_take", 32'(bus.s_rready), 32'd1);
    check("busy_after_take", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    int a;
    int b;
    reset         = 1'b1;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = 8'h00;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data",  32'(bus.res_data),  32'd0);
    check("rst_res_err",   32'(bus.res_err),   32'd0);
    check("rst_s_rready",  32'(bus.s_rready),  32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_op_count",  32'(op_count),      32'd0);
    reset = 1'b0;

    // Gap-free ADD frame: three accepts in three cycles, then latency check.
    accept_cycles = 0;
    send_frame(8'h00, 8'h7F, 8'h81, 0);
    check("accept_cycles", 32'(accept_cycles), 32'd3);
    check("add_exp", 32'(exp_q[0]), 32'h0_0100);
    @(negedge clk);
    check("exec_no_valid", 32'(bus.res_valid), 32'd0);
    check("exec_no_rready", 32'(bus.s_rready), 32'd0);
    @(posedge clk); #1;
    check("latency_valid", 32'(bus.res_valid), 32'd1);
    get_result(0);

    send_frame(8'h01, 8'h05, 8'h07, 0); get_result(0);
    send_frame(8'h05, 8'hFF, 8'hFF, 0); get_result(0);
    send_frame(8'h06, 8'h81, 8'h0B, 0); get_result(0);

    // Illegal opcode followed by a legal frame: framing must survive.
    send_frame(8'h09, 8'h12, 8'h34, 0); get_result(0);
    send_frame(8'h00, 8'h12, 8'h34, 0); get_result(0);

    // Back-pressure with a byte waiting upstream.
    send_frame(8'h04, 8'hA5, 8'h3C, 0);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 8'h03;
    get_result(10);
    send_frame(8'h03, 8'h50, 8'h0A, 0); get_result(0);

    // Same frames with random gaps.
    send_frame(8'h01, 8'h05, 8'h07, 4); get_result($urandom_range(0, 3));
    send_frame(8'h05, 8'hFF, 8'hFF, 4); get_result($urandom_range(0, 3));
    send_frame(8'h07, 8'hC3, 8'h05, 4); get_result($urandom_range(0, 3));

    // Reset after the A byte: partial frame discarded.
    push_byte(8'h00, 0);
    push_byte(8'h44, 0);
    bus.s_rvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_model = 0;
    check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_res_data",  32'(bus.res_data),  32'd0);
    check("mid_rst_s_rready",  32'(bus.s_rready),  32'd1);
    check("mid_rst_busy",      32'(busy),          32'd0);
    check("mid_rst_op_count",  32'(op_count),      32'd0);
    send_frame(8'h02, 8'hF0, 8'h3C, 0); get_result(0);

    // Randomized frames up to 256 handshakes since reset: counter wraps.
    for (int i = 1; i < 256; i++) begin
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 255) : $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      send_frame(op, a, b, 2);
      get_result($urandom_range(0, 2));
    end
    check("op_count_wrap", 32'(op_count), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
